stack_cpu_param: RTL and testbench

- Parametrised single-issue stack machine: instruction memory, data stack, data memory, PC and SP.
- Executes one instruction per clock in RUN.
- Successor to the fixed 8-bit stack engine. Adds configurable widths and depth, a program-load port, an IDLE/RUN/HALT FSM, DUP/SWAP/DROP/HALT opcodes, and fault detection with a cause code instead of silent stalling.
- Sits as a standalone compute tile driven by a host that loads code and reads results.

---
 rtl/stack_cpu_param.sv | 249 ++++++++++++++++++++++++
 tb/tb_stack_cpu_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_cpu_param.sv
// Parametrised single-issue stack machine tile with program-load port and fault halting.
// Optional MUL opcode (14) is enabled by defining STACK_CPU_MUL_EN.
module stack_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0]   prog_data,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data,
  output logic [1:0]          state,
  output logic [1:0]          halt_cause,
  output logic                guard,
  output logic [ADDR_W-1:0]   pc,
  output logic [SP_W:0]       sp,
  output logic [DATA_W-1:0]   tos
);

  localparam int DEPTH = 2 ** SP_W;
  localparam int IW    = DATA_W + 4;

  localparam logic [3:0] OP_PUSH  = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_JF    = 4'd5;
  localparam logic [3:0] OP_JB    = 4'd6;
  localparam logic [3:0] OP_JEQ   = 4'd7;
  localparam logic [3:0] OP_JNE   = 4'd8;
  localparam logic [3:0] OP_JLE   = 4'd9;
  localparam logic [3:0] OP_JLT   = 4'd10;
  localparam logic [3:0] OP_DUP   = 4'd11;
  localparam logic [3:0] OP_SWAP  = 4'd12;
  localparam logic [3:0] OP_DROP  = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // The reset port keeps its historical name but is active-high.
  logic srst;
  assign srst = rst_n;

  logic [IW-1:0]     imem [2**ADDR_W];
  logic [DATA_W-1:0] dmem [2**ADDR_W];
  logic [DATA_W-1:0] stk  [DEPTH];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [SP_W:0]     sp_reg, sp_next;
  logic [1:0]        cause_reg, cause_next;

  logic [IW-1:0]     instr;
  logic [3:0]        op;
  logic [DATA_W-1:0] arg;
  logic [ADDR_W-1:0] arg_addr;
  logic [SP_W-1:0]   push_idx, t_idx, n_idx;
  logic [DATA_W-1:0] t_val, n_val;
  logic              sp_ge1, sp_ge2, sp_full;
  logic [ADDR_W-1:0] pc_inc, pc_fwd, pc_back;

  logic              need1, need2, pushes, illegal;
  logic              underflow, overflow;

  logic              imem_we;
  logic              dmem_we;
  logic              stk_we_a, stk_we_b;
  logic [SP_W-1:0]   stk_idx_a, stk_idx_b;
  logic [DATA_W-1:0] stk_data_a, stk_data_b;

  assign instr    = imem[pc_reg];
  assign op       = instr[3:0];
  assign arg      = instr[IW-1:4];
  assign arg_addr = arg[ADDR_W-1:0];

  // Low SP_W bits of sp index the next free slot; T and N sit just below it.
  assign push_idx = sp_reg[SP_W-1:0];
  assign t_idx    = push_idx - SP_ONE;
  assign n_idx    = push_idx - SP_ONE - SP_ONE;
  assign t_val    = stk[t_idx];
  assign n_val    = stk[n_idx];

  assign sp_ge1  = (sp_reg != '0);
  assign sp_ge2  = (sp_reg >= (SP_W+1)'(2));
  assign sp_full = (sp_reg == (SP_W+1)'(DEPTH));

  assign pc_inc  = pc_reg + ADDR_W'(1);
  assign pc_fwd  = pc_reg + ADDR_W'(1) + arg_addr;
  assign pc_back = pc_reg + ADDR_W'(1) - arg_addr;

  // Stack-depth demands of each opcode.
  always_comb begin
    need1   = 1'b0;
    need2   = 1'b0;
    pushes  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_PUSH, OP_LOAD:              pushes = 1'b1;
      OP_DUP:                        begin need1 = 1'b1; pushes = 1'b1; end
      OP_STORE, OP_DROP:             need1 = 1'b1;
      OP_ADD, OP_SUB, OP_SWAP,
      OP_JEQ, OP_JNE, OP_JLE, OP_JLT: need2 = 1'b1;
`ifdef STACK_CPU_MUL_EN
      OP_MUL:                        need2 = 1'b1;
`else
      OP_MUL:                        illegal = 1'b1;
`endif
      default:                       ;
    endcase
  end

  assign underflow = (need2 && !sp_ge2) || (need1 && !sp_ge1);
  assign overflow  = pushes && sp_full;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      sp_reg    <= '0;
      cause_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      sp_reg    <= sp_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    sp_next    = sp_reg;
    cause_next = cause_reg;
    guard      = 1'b0;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    stk_we_a   = 1'b0;
    stk_we_b   = 1'b0;
    stk_idx_a  = push_idx;
    stk_idx_b  = n_idx;
    stk_data_a = arg;
    stk_data_b = t_val;
    case (state_reg)
      RUN: begin
        // Faults and HALT freeze every architectural register and memory.
        if (illegal) begin
          state_next = HALT;
          cause_next = 2'd1;
        end else if (underflow) begin
          state_next = HALT;
          cause_next = 2'd2;
        end else if (overflow) begin
          state_next = HALT;
          cause_next = 2'd3;
        end else if (op == OP_HALT) begin
          state_next = HALT;
          cause_next = 2'd0;
        end else begin
          guard   = 1'b1;
          pc_next = pc_inc;
          case (op)
            OP_PUSH: begin
              stk_we_a = 1'b1;
              sp_next  = sp_reg + (SP_W+1)'(1);
            end
            OP_LOAD: begin
              stk_we_a   = 1'b1;
              stk_data_a = dmem[arg_addr];
              sp_next    = sp_reg + (SP_W+1)'(1);
            end
            OP_DUP: begin
              stk_we_a   = 1'b1;
              stk_data_a = t_val;
              sp_next    = sp_reg + (SP_W+1)'(1);
            end
            OP_STORE: begin
              dmem_we = 1'b1;
              sp_next = sp_reg - (SP_W+1)'(1);
            end
            OP_DROP: sp_next = sp_reg - (SP_W+1)'(1);
            OP_ADD, OP_SUB, OP_MUL: begin
              stk_we_a  = 1'b1;
              stk_idx_a = n_idx;
              if (op == OP_ADD)      stk_data_a = n_val + t_val;
              else if (op == OP_SUB) stk_data_a = n_val - t_val;
              else                   stk_data_a = n_val * t_val;
              sp_next = sp_reg - (SP_W+1)'(1);
            end
            OP_SWAP: begin
              stk_we_a   = 1'b1;
              stk_idx_a  = t_idx;
              stk_data_a = n_val;
              stk_we_b   = 1'b1;
            end
            OP_JF: pc_next = pc_fwd;
            OP_JB: pc_next = pc_back;
            OP_JEQ, OP_JNE, OP_JLE, OP_JLT: begin
              sp_next = sp_reg - (SP_W+1)'(2);
              if ((op == OP_JEQ && n_val == t_val) ||
                  (op == OP_JNE && n_val != t_val) ||
                  (op == OP_JLE && n_val <= t_val) ||
                  (op == OP_JLT && t_val <  n_val))
                pc_next = pc_fwd;
            end
            default: ;
          endcase
        end
      end
      default: begin
        imem_we = prog_we;
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
          sp_next    = '0;
        end
      end
    endcase
  end

  // Memories are never cleared, but reset suppresses any write in that cycle.
  always_ff @(posedge clk) begin
    if (!srst) begin
      if (imem_we)  imem[prog_addr] <= prog_data;
      if (dmem_we)  dmem[arg_addr]  <= t_val;
      if (stk_we_a) stk[stk_idx_a]  <= stk_data_a;
      if (stk_we_b) stk[stk_idx_b]  <= stk_data_b;
    end
  end

  assign dbg_data   = dmem[dbg_addr];
  assign state      = state_reg;
  assign halt_cause = cause_reg;
  assign pc         = pc_reg;
  assign sp         = sp_reg;
  assign tos        = sp_ge1 ? t_val : '0;

endmodule

// File: tb/tb_stack_cpu_param.sv
// Directed bench for stack_cpu_param (DATA_W=8, ADDR_W=8, SP_W=2); honours STACK_CPU_MUL_EN.
module tb_stack_cpu_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic        guard;
  logic [7:0]  pc;
  logic [2:0]  sp;
  logic [7:0]  tos;

  int checks = 0;
  int errors = 0;
  int gcount;

  stack_cpu_param #(.DATA_W(8), .ADDR_W(8), .SP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .state(state), .halt_cause(halt_cause),
    .guard(guard), .pc(pc), .sp(sp), .tos(tos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] op, input logic [7:0] arg);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = {arg, op};
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic run_until_halt(input string tag);
    int n = 0;
    while (state != 2'd2 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_halted"}, state, 2);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_addr = '0;
    tick(); tick();
    rst_n = 1'b0;
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_sp", sp, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_guard", guard, 0);
    check("rst_tos", tos, 0);

    // PUSH 5, PUSH 7, ADD, STORE 3, HALT
    load(0, 4'd0, 5); load(1, 4'd0, 7); load(2, 4'd3, 0); load(3, 4'd2, 3); load(4, 4'd15, 0);
    pulse_start();
    check("t1_run", state, 1);
    gcount = 0;
    for (int i = 0; i < 5; i++) begin
      gcount += int'(guard);
      tick();
    end
    check("t1_state", state, 2);
    check("t1_cause", halt_cause, 0);
    check("t1_pc", pc, 4);
    check("t1_sp", sp, 0);
    check("t1_guard_cycles", gcount, 4);
    dbg_addr = 3; #1;
    check("t1_dmem3", dbg_data, 12);

    // PUSH 3, PUSH 3, JEQ 2, PUSH 1, HALT, PUSH 9, HALT
    load(0, 4'd0, 3); load(1, 4'd0, 3); load(2, 4'd7, 2); load(3, 4'd0, 1);
    load(4, 4'd15, 0); load(5, 4'd0, 9); load(6, 4'd15, 0);
    pulse_start();
    tick(); tick(); tick();
    check("t2_branch_pc", pc, 5);
    check("t2_branch_sp", sp, 0);
    run_until_halt("t2");
    check("t2_tos", tos, 9);
    check("t2_sp", sp, 1);
    check("t2_pc", pc, 6);
    load(1, 4'd0, 4);
    pulse_start();
    run_until_halt("t2b");
    check("t2b_tos", tos, 1);
    check("t2b_sp", sp, 1);
    check("t2b_pc", pc, 4);

    // Overflow at depth 4, then underflow
    for (int i = 0; i < 5; i++) load(8'(i), 4'd0, 1);
    pulse_start();
    run_until_halt("t3");
    check("t3_cause", halt_cause, 3);
    check("t3_sp", sp, 4);
    check("t3_pc", pc, 4);
    check("t3_tos", tos, 1);
    load(1, 4'd3, 0);
    pulse_start();
    check("t3b_cause_kept", halt_cause, 3);
    run_until_halt("t3b");
    check("t3b_cause", halt_cause, 2);
    check("t3b_sp", sp, 1);
    check("t3b_pc", pc, 1);

    // Reset mid-RUN and prog_we ignored during RUN: PUSH 1, JB 1 (spins at pc=1)
    load(1, 4'd6, 1);
    pulse_start();
    tick(); tick();
    check("t5_spin_state", state, 1);
    check("t5_spin_pc", pc, 1);
    check("t5_spin_guard", guard, 1);
    prog_we = 1'b1; prog_addr = 1; prog_data = {8'd0, 4'd15};
    tick();
    prog_we = 1'b0;
    tick();
    check("t5_imem_protected", state, 1);
    check("t5_sp", sp, 1);
    start = 1'b1;
    do_reset();
    start = 1'b0;
    check("t5_rst_state", state, 0);
    check("t5_rst_pc", pc, 0);
    check("t5_rst_sp", sp, 0);
    check("t5_rst_cause", halt_cause, 0);

    // PC wrap: JF 254 at 0, JF 0 at 255
    load(0, 4'd5, 254); load(255, 4'd5, 0);
    pulse_start();
    tick();
    check("t4_pc255", pc, 255);
    tick();
    check("t4_wrap_pc", pc, 0);
    check("t4_wrap_state", state, 1);
    do_reset();
    load(0, 4'd0, 250); load(1, 4'd0, 10); load(2, 4'd3, 0); load(3, 4'd15, 0);
    pulse_start();
    run_until_halt("t4b");
    check("t4b_tos", tos, 4);
    check("t4b_sp", sp, 1);

    // Opcode 14 with 7 on top of 6
    load(0, 4'd0, 6); load(1, 4'd0, 7); load(2, 4'd14, 0); load(3, 4'd15, 0);
    pulse_start();
    run_until_halt("t6");
`ifdef STACK_CPU_MUL_EN
    check("t6_mul_tos", tos, 42);
    check("t6_mul_sp", sp, 1);
    check("t6_mul_cause", halt_cause, 0);
`else
    check("t6_ill_cause", halt_cause, 1);
    check("t6_ill_sp", sp, 2);
    check("t6_ill_pc", pc, 2);
    check("t6_ill_tos", tos, 7);
`endif

    // SWAP/SUB/DUP/JLE/JLT/STORE/LOAD/DROP/JNE walk
    load(0, 4'd0, 3);   load(1, 4'd0, 10);  load(2, 4'd12, 0); load(3, 4'd4, 0);
    load(4, 4'd11, 0);  load(5, 4'd9, 1);   load(6, 4'd15, 0); load(7, 4'd0, 2);
    load(8, 4'd0, 5);   load(9, 4'd10, 1);  load(10, 4'd0, 7); load(11, 4'd2, 20);
    load(12, 4'd1, 20); load(13, 4'd13, 0); load(14, 4'd1, 20); load(15, 4'd0, 7);
    load(16, 4'd8, 1);  load(17, 4'd1, 3);  load(18, 4'd15, 0);
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    check("t7_dup_sp", sp, 2);
    check("t7_sub_tos", tos, 7);
    check("t7_dup_pc", pc, 5);
    run_until_halt("t7");
    check("t7_pc", pc, 18);
    check("t7_sp", sp, 1);
    check("t7_tos", tos, 12);
    check("t7_cause", halt_cause, 0);
    dbg_addr = 20; #1;
    check("t7_dmem20", dbg_data, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
